// File: rtl/exe_muldiv.sv
// exe_muldiv: multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
// It accepts one M-extension op per start/ready handshake and stalls the pipe
// through busy_o while it computes. The result comes back as a registered
// write-back (valid/ack) on reg_waddr_o / reg_wdata_o.
// Multiply takes a single compute cycle. Divide and remainder use a radix-2
// restoring divider that produces one quotient bit per cycle.
// Optional macro EXE_MULDIV_EARLY_OUT_EN lets divide-by-zero, signed overflow
// and |divisor| > |dividend| skip the iterations. Results are the same either way.
//
// state | meaning
// IDLE  | ready for a new op
// MUL   | form the 2*XLEN product and select the half the op asks for
// DPREP | take operand magnitudes, record result signs, load divider
// DIV   | one restoring-division step per cycle, XLEN steps
// DONE  | load output registers, then hold the result until ack_i

module exe_muldiv #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               flush_i,
    input  logic               ack_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               valid_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [XLEN-1:0]    reg_wdata_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DPREP,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]         op_q;
    logic [XLEN-1:0]    a_q, b_q;
    logic [RADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]    result_q;
    logic [XLEN-1:0]    dvd_q;      // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]    dvs_q;
    logic [XLEN-1:0]    rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               q_neg_q, r_neg_q;

    logic               out_valid_q;
    logic [RADDR_W-1:0] out_waddr_q;
    logic [XLEN-1:0]    out_wdata_q;

    logic accept;
    assign accept = start_i && (state_q == S_IDLE);

    // Multiply: sign- or zero-extend both operands to 2*XLEN. The low 2*XLEN
    // bits of the product are then exact for every signedness mix.
    logic               a_msb_sgn, b_msb_sgn;
    logic [2*XLEN-1:0]  a_ext, b_ext, prod;
    logic [XLEN-1:0]    mul_res;

    always_comb begin
        a_msb_sgn = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1];
        b_msb_sgn = (op_q == OP_MULH) && b_q[XLEN-1];
        a_ext     = {{XLEN{a_msb_sgn}}, a_q};
        b_ext     = {{XLEN{b_msb_sgn}}, b_q};
        prod      = a_ext * b_ext;
        mul_res   = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Divide: operand magnitudes, special-case results and one restoring step
    logic            div_signed, is_rem, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   rem_shift, diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_next, dvd_next, q_fix, r_fix, div_res;
    logic            early_out;

    always_comb begin
        div_signed = ~op_q[0];
        is_rem     = op_q[1];
        a_neg      = div_signed && a_q[XLEN-1];
        b_neg      = div_signed && b_q[XLEN-1];
        abs_a      = a_neg ? ('0 - a_q) : a_q;
        abs_b      = b_neg ? ('0 - b_q) : b_q;
        div_zero   = (b_q == '0);
        div_ovf    = div_signed && (a_q == MIN_NEG) && (b_q == '1);

        // Small-quotient case falls in the last branch: quotient 0, remainder = dividend
        if (div_zero)
            special_res = is_rem ? a_q : '1;
        else if (div_ovf)
            special_res = is_rem ? '0 : a_q;
        else
            special_res = is_rem ? a_q : '0;

        rem_shift = {rem_q, dvd_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        q_bit     = ~diff[XLEN];
        rem_next  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        dvd_next  = {dvd_q[XLEN-2:0], q_bit};
        q_fix     = q_neg_q ? ('0 - dvd_next) : dvd_next;
        r_fix     = r_neg_q ? ('0 - rem_next) : rem_next;

        if (div_zero || div_ovf)
            div_res = special_res;
        else
            div_res = is_rem ? r_fix : q_fix;

`ifdef EXE_MULDIV_EARLY_OUT_EN
        early_out = div_zero || div_ovf || (abs_b > abs_a);
`else
        early_out = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; a flush returns any busy state to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = op_i[2] ? S_DPREP : S_MUL;
            S_MUL:   state_d = S_DONE;
            S_DPREP: state_d = early_out ? S_DONE : S_DIV;
            S_DIV:   if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  if (out_valid_q && ack_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i && (state_q != S_IDLE))
            state_d = S_IDLE;
    end

    // Operand latch, multiply/divide datapath and registered write-back outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            waddr_q     <= '0;
            result_q    <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_waddr_q <= '0;
            out_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= op_i;
                        a_q     <= op1_i;
                        b_q     <= op2_i;
                        waddr_q <= reg_waddr_i;
                    end
                end
                S_MUL: result_q <= mul_res;
                S_DPREP: begin
                    dvd_q   <= abs_a;
                    dvs_q   <= abs_b;
                    rem_q   <= '0;
                    cnt_q   <= CNT_LOAD;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    if (early_out)
                        result_q <= special_res;
                end
                S_DIV: begin
                    dvd_q <= dvd_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST)
                        result_q <= div_res;
                end
                S_DONE: begin
                    if (flush_i) begin
                        out_valid_q <= 1'b0;
                    end else if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_waddr_q <= waddr_q;
                        out_wdata_q <= result_q;
                    end else if (ack_i) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign valid_o     = out_valid_q;
    assign reg_waddr_o = out_waddr_q;
    assign reg_wdata_o = out_wdata_q;
    assign reg_we_o    = out_valid_q && (out_waddr_q != '0);

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv (XLEN=32). It checks results, latency from the
// accept edge, the handshake and stall behaviour, flush and reset.
module tb_exe_muldiv;

    localparam int LAT_MUL = 2;
    localparam int LAT_DIV = 34;
`ifdef EXE_MULDIV_EARLY_OUT_EN
    localparam int LAT_SPC = 2;
`else
    localparam int LAT_SPC = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i, ack_i;
    logic        ready_o, busy_o, valid_o, reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int checks = 0;
    int errors = 0;

    exe_muldiv #(.XLEN(32), .RADDR_W(5)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .ack_i       (ack_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request; called #1 after a rising edge, returns #1 after the accept edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa);
        start_i     = 1'b1;
        op_i        = op;
        op1_i       = a;
        op2_i       = b;
        reg_waddr_i = wa;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Edges after the accept edge until valid_o is seen; -1 when the budget expires
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        @(posedge clk);
        #1;
        ack_i = 1'b0;
    endtask

    // Full transaction: issue, result, latency, write-back fields, ack back to IDLE
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp_data, input int exp_lat);
        int lat;
        issue(op, a, b, wa);
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, 64'(reg_wdata_o), 64'(exp_data));
        check({tag, "_waddr"}, 64'(reg_waddr_o), 64'(wa));
        check({tag, "_we"}, 64'(reg_we_o), 64'(wa != 5'd0));
        do_ack();
        check({tag, "_idle_valid"}, 64'(valid_o), 64'd0);
        check({tag, "_idle_ready"}, 64'(ready_o), 64'd1);
    endtask

    // Confirm no result ever appears within a window
    task automatic watch_no_valid(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        op_i        = 3'd0;
        op1_i       = '0;
        op2_i       = '0;
        reg_waddr_i = '0;
        flush_i     = 1'b0;
        ack_i       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1'b1;

        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_we", 64'(reg_we_o), 64'd0);
        check("rst_waddr", 64'(reg_waddr_o), 64'd0);
        check("rst_wdata", 64'(reg_wdata_o), 64'd0);

        // Reset held two cycles in the middle of a divide discards it
        issue(3'd5, 32'd100, 32'd7, 5'd3);
        repeat (5) @(posedge clk);
        #1;
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        check("midrst_ready", 64'(ready_o), 64'd1);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        watch_no_valid("midrst_no_wb", 40);

        // Multiply family
        run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 32'hFFFF_FFFF, LAT_MUL);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6, 32'h0000_0001, LAT_MUL);
        run_op("mul",    3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7, 32'hFFFF_FFFE, LAT_MUL);
        run_op("mulhsu", 3'd2, 32'h0000_0002, 32'hFFFF_FFFF, 5'd8, 32'h0000_0001, LAT_MUL);

        // Divide family
        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFD, LAT_DIV);
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, LAT_DIV);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14, LAT_DIV);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2, LAT_DIV);

        // Special cases
        run_op("divu_by0", 3'd5, 32'h1234_5678, 32'd0, 5'd13, 32'hFFFF_FFFF, LAT_SPC);
        run_op("remu_by0", 3'd7, 32'h1234_5678, 32'd0, 5'd14, 32'h1234_5678, LAT_SPC);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, LAT_SPC);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, LAT_SPC);
        run_op("div_small", 3'd4, 32'd3, 32'hFFFF_FFFB, 5'd17, 32'd0, LAT_SPC);
        run_op("rem_small", 3'd6, 32'd3, 32'hFFFF_FFFB, 5'd18, 32'd3, LAT_SPC);

        // Stall: result held without ack, a stray start is ignored
        issue(3'd0, 32'd3, 32'd4, 5'd7);
        wait_valid(lat);
        check("stall_lat", 64'(lat), 64'(LAT_MUL));
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                start_i = 1'b1;
                op_i    = 3'd3;
                op1_i   = 32'hFFFF_FFFF;
                op2_i   = 32'hFFFF_FFFF;
                reg_waddr_i = 5'd9;
            end
            @(posedge clk);
            #1;
            start_i = 1'b0;
            check("stall_valid", 64'(valid_o), 64'd1);
            check("stall_busy", 64'(busy_o), 64'd1);
            check("stall_data", 64'(reg_wdata_o), 64'd12);
            check("stall_waddr", 64'(reg_waddr_o), 64'd7);
        end
        do_ack();
        check("stall_ack_valid", 64'(valid_o), 64'd0);
        check("stall_ack_ready", 64'(ready_o), 64'd1);
        watch_no_valid("stall_start_ignored", 5);

        // Destination x0: handshake still happens, no write enable
        run_op("x0_dest", 3'd0, 32'd5, 32'd6, 5'd0, 32'd30, LAT_MUL);

        // Flush on divide iteration 10 together with ack
        issue(3'd5, 32'd100, 32'd7, 5'd4);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        ack_i   = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        ack_i   = 1'b0;
        check("flush_ready", 64'(ready_o), 64'd1);
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_valid", 64'(valid_o), 64'd0);
        watch_no_valid("flush_no_wb", 40);
        run_op("post_flush_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE, LAT_MUL);

        // Flush in IDLE does not block a simultaneous start
        flush_i = 1'b1;
        issue(3'd0, 32'd7, 32'd8, 5'd21);
        flush_i = 1'b0;
        wait_valid(lat);
        check("idle_flush_lat", 64'(lat), 64'(LAT_MUL));
        check("idle_flush_data", 64'(reg_wdata_o), 64'd56);
        do_ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Parametrised multi-cycle RV32M/RV64M multiply/divide unit that sits beside the combinational execute stage. It accepts one M-extension operation per handshake and holds the pipeline via busy_o while it computes. It returns a register write-back (address, data, enable) with a valid/ack handshake into the exe_mem path. Multiply completes in a fixed short latency; divide/remainder use an iterative radix-2 restoring divider.

Parameters:
XLEN, 32, operand/result width (32 or 64)
RADDR_W, 5, register address width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  synchronous active-low reset
start_i  in  1  request; accepted when start_i && ready_o
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1_i  in  XLEN  rs1 value
op2_i  in  XLEN  rs2 value
reg_waddr_i  in  RADDR_W  destination register
flush_i  in  1  abort in-flight op
ack_i  in  1  consumer accepts result
ready_o  out  1  unit is IDLE, can accept
busy_o  out  1  op in flight or result unconsumed (stall request)
valid_o  out  1  result valid
reg_we_o  out  1  write enable; equals valid_o && reg_waddr_o != 0
reg_waddr_o  out  RADDR_W  latched destination
reg_wdata_o  out  XLEN  result

Behaviour:
- Reset (rst_n_i=0 at clock edge): state IDLE, ready_o=1, busy_o=0, valid_o=0, reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0. Reset mid-operation discards the op; no result is produced.
- States: IDLE, MUL, DPREP, DIV, DONE.
- IDLE: on accept, latch op, operands and waddr. Go to MUL for op<4, otherwise DPREP. start_i is ignored in all other states.
- MUL: one cycle. Form a 2*XLEN product with operand signedness per op (MULHSU: op1 signed, op2 unsigned). MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits. Next state DONE.
- Multiply latency: accept at edge T, valid_o high after edge T+2.
- DPREP: one cycle. Take absolute values for signed ops and record quotient/remainder sign (remainder sign = dividend sign). Next state DIV.
- DIV: exactly XLEN iterations, one quotient bit per cycle, MSB first, tracked by an iteration counter of width clog2(XLEN)+1. After the last iteration, apply the sign fix and go to DONE.
- Divide latency: valid_o high after edge T+XLEN+2.
- Division by zero: quotient = all ones; remainder = op1.
- Signed overflow (op1 = most negative, op2 = -1): quotient = op1; remainder = 0.
- Without the optional feature, both special cases still take the full divide latency.
- DONE: valid_o=1; outputs hold stable until ack_i. On ack_i, go to IDLE next cycle (valid_o=0, ready_o=1). There is no back-to-back accept in the same cycle as ack.
- busy_o = state != IDLE.
- flush_i: in any non-IDLE state, go to IDLE next edge and never assert valid_o. flush_i has priority over ack_i. A flush in IDLE is a no-op and does not block a simultaneous start_i.
- reg_we_o=0 when destination is x0, but valid_o/ack handshake still occurs.

Optional Feature:
EXE_MULDIV_EARLY_OUT_EN
- Defined: in DPREP, division by zero, signed overflow, and |op2| > |op1| (quotient 0, remainder = op1) jump directly to DONE, giving valid_o after edge T+2.
- Undefined: all divide ops take XLEN+2 cycles.
- Results are identical in both builds.

Test Plan:
- Reset: hold rst_n_i=0 two cycles mid-DIV, release -> ready_o=1, valid_o=0, no write-back ever appears.
- MULH signed: XLEN=32, op1=0xFFFFFFFF, op2=0x00000002, op_i=1 -> reg_wdata_o=0xFFFFFFFF at T+2. MULHU with the same operands -> 0x00000001. MUL with the same operands -> 0xFFFFFFFE.
- DIV/REM signed: op1=-7 (0xFFFFFFF9), op2=2 -> DIV result 0xFFFFFFFD, REM result 0xFFFFFFFF. valid_o at T+34 without the feature.
- Special cases: DIVU x/0 -> 0xFFFFFFFF. REM 0x80000000 % 0xFFFFFFFF -> 0. DIV 0x80000000 / -1 -> 0x80000000. Latency is T+34 without the feature and T+2 with EXE_MULDIV_EARLY_OUT_EN.
- Handshake/stall: hold ack_i=0 five cycles after valid_o -> outputs stable, busy_o=1, a start_i pulse is ignored. ack_i=1 -> IDLE next cycle; the next start is accepted. With reg_waddr_i=0 -> valid_o=1, reg_we_o=0.
- Flush: assert flush_i on DIV iteration 10 together with ack_i -> IDLE next edge, valid_o never asserted. A following MULHU is accepted and correct.
